// File: rtl/uart_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_instr_loader
//  Description : Boot-time loader. Receives an 8N1 serial program image
//                (0xA5, 16-bit word count, then 32-bit words, MSB first),
//                writes it into instruction memory and holds the core in
//                reset until the whole image has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_instr_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    // Bit-period counter sizing and sample points
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      c_DEPTH     = 17'(DEPTH);
    localparam logic [7:0]       c_HEADER    = 8'hA5;

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Loader states
    localparam logic [2:0] L_HDR    = 3'd0;
    localparam logic [2:0] L_CNT_HI = 3'd1;
    localparam logic [2:0] L_CNT_LO = 3'd2;
    localparam logic [2:0] L_DATA   = 3'd3;
    localparam logic [2:0] L_WRITE  = 3'd4;
    localparam logic [2:0] L_DONE   = 3'd5;
    localparam logic [2:0] L_ERR    = 3'd6;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                  rx_meta_q, rx_sync_q;

    logic [1:0]            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [2:0]            rx_bit_q, rx_bit_d;
    logic [7:0]            rx_shift_q, rx_shift_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic [2:0]            ld_state_q, ld_state_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic [15:0]           words_q, words_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [15:0]           w_count_rx;
    logic [15:0]           w_words_inc;
    logic [31:0]           w_word_next;

    assign w_count_rx  = {count_q[15:8], rx_shift_q};
    assign w_words_inc = words_q + 16'd1;
    assign w_word_next = {asm_q[23:0], rx_shift_q};

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver next-state: mid-bit sampling, byte_valid / frame_err pulses
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == c_HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;     // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == c_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == c_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) byte_valid_d = 1'b1;
                    else           frame_err_d  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Loader next-state: header/count parsing, word assembly, memory writes
    always_comb begin
        ld_state_d = ld_state_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        words_d    = words_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        if (frame_err_q && (ld_state_q != L_DONE) && (ld_state_q != L_ERR)) begin
            ld_state_d = L_ERR;
            err_d      = 1'b1;
            hold_d     = 1'b1;
            done_d     = 1'b0;
        end else begin
            case (ld_state_q)
                L_HDR: begin
                    if (byte_valid_q && (rx_shift_q == c_HEADER)) ld_state_d = L_CNT_HI;
                end
                L_CNT_HI: begin
                    if (byte_valid_q) begin
                        count_d[15:8] = rx_shift_q;
                        ld_state_d    = L_CNT_LO;
                    end
                end
                L_CNT_LO: begin
                    if (byte_valid_q) begin
                        count_d = w_count_rx;
                        if (w_count_rx == 16'd0) begin
                            ld_state_d = L_DONE;
                            done_d     = 1'b1;
                            hold_d     = 1'b0;
                        end else if ({1'b0, w_count_rx} > c_DEPTH) begin
                            ld_state_d = L_ERR;
                            err_d      = 1'b1;
                        end else begin
                            ld_state_d = L_DATA;
                            byte_idx_d = 2'd0;
                        end
                    end
                end
                L_DATA: begin
                    if (byte_valid_q) begin
                        asm_d = w_word_next;
                        if (byte_idx_q == 2'd3) begin
                            // Strobe is registered, so it is high for exactly the L_WRITE cycle
                            ld_state_d = L_WRITE;
                            byte_idx_d = 2'd0;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = words_q[ADDR_WIDTH-1:0];
                            wr_data_d  = w_word_next;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
                L_WRITE: begin
                    words_d = w_words_inc;
                    if (w_words_inc == count_q) begin
                        ld_state_d = L_DONE;
                        done_d     = 1'b1;
                        hold_d     = 1'b0;
                    end else begin
                        ld_state_d = L_DATA;
                    end
                end
                L_DONE:  ld_state_d = L_DONE;
                L_ERR:   ld_state_d = L_ERR;
                default: ld_state_d = L_ERR;
            endcase
        end
    end

    // Loader state and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_state_q <= L_HDR;
            count_q    <= 16'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            words_q    <= 16'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            words_q    <= words_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_instr_loader
//  Description : Directed self-checking bench for uart_instr_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_instr_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx    = 1'b1;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [15:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    // Strobe log, written only by the monitor
    int            n_strobes = 0;
    logic [AW-1:0] st_addr [64];
    logic [31:0]   st_data [64];

    uart_instr_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .DEPTH       (256)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    // Record every write strobe, sampled mid-cycle
    always @(negedge clock) begin
        if (imem_wr_en === 1'b1) begin
            if (n_strobes < 64) begin
                st_addr[n_strobes] = imem_wr_addr;
                st_data[n_strobes] = imem_wr_data;
            end
            n_strobes = n_strobes + 1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v  = b;
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            cycles(CPB);
        end
        rx = stop_bit;
        cycles(CPB);
        rx = 1'b1;
        cycles(2 * CPB);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        rx    = 1'b1;
        cycles(3);
        reset = 1'b1;
        cycles(3);
    endtask

    task automatic test_reset();
        int base;
        do_reset();
        base = n_strobes;
        total++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 ||
            words_loaded !== 16'd0 || imem_wr_addr !== 8'd0 || imem_wr_data !== 32'd0 ||
            imem_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: hold=%b done=%b err=%b words=%0d addr=%h data=%h en=%b required 1 0 0 0 00 00000000 0",
                     cpu_hold, load_done, load_error, words_loaded, imem_wr_addr, imem_wr_data, imem_wr_en);
        end
        cycles(1000);
        total++;
        if (n_strobes != base || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_1000: strobes=%0d hold=%b done=%b required 0 1 0",
                     n_strobes - base, cpu_hold, load_done);
        end
    endtask

    task automatic test_two_words();
        int base;
        logic [7:0] img [11] = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                                 8'h12, 8'h34, 8'h56, 8'h78};
        do_reset();
        base = n_strobes;
        foreach (img[i]) send(img[i]);
        cycles(20);
        total++;
        if (n_strobes - base != 2) begin
            bad++;
            $display("FAIL two_words_count: strobes=%0d required 2", n_strobes - base);
        end
        if (n_strobes - base >= 2) begin
            total++;
            if (st_addr[base] !== 8'd0 || st_data[base] !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL word0: addr=%h data=%h required 00 deadbeef", st_addr[base], st_data[base]);
            end
            total++;
            if (st_addr[base+1] !== 8'd1 || st_data[base+1] !== 32'h12345678) begin
                bad++;
                $display("FAIL word1: addr=%h data=%h required 01 12345678", st_addr[base+1], st_data[base+1]);
            end
        end
        total++;
        if (words_loaded !== 16'd2 || load_done !== 1'b1 || cpu_hold !== 1'b0 || load_error !== 1'b0) begin
            bad++;
            $display("FAIL two_words_done: words=%0d done=%b hold=%b err=%b required 2 1 0 0",
                     words_loaded, load_done, cpu_hold, load_error);
        end
        send(8'hFF);
        cycles(20);
        total++;
        if (n_strobes - base != 2 || words_loaded !== 16'd2 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL after_done_byte: strobes=%0d words=%0d done=%b hold=%b required 2 2 1 0",
                     n_strobes - base, words_loaded, load_done, cpu_hold);
        end
    endtask

    task automatic test_zero_count();
        int base;
        do_reset();
        base = n_strobes;
        send(8'h3C);
        cycles(10);
        total++;
        if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL junk_ignored: done=%b hold=%b required 0 1", load_done, cpu_hold);
        end
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        cycles(20);
        total++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || n_strobes != base || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL zero_count: done=%b hold=%b strobes=%0d words=%0d required 1 0 0 0",
                     load_done, cpu_hold, n_strobes - base, words_loaded);
        end
    endtask

    task automatic test_oversize();
        int base;
        do_reset();
        base = n_strobes;
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        cycles(20);
        total++;
        if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || n_strobes != base) begin
            bad++;
            $display("FAIL oversize: err=%b hold=%b done=%b strobes=%0d required 1 1 0 0",
                     load_error, cpu_hold, load_done, n_strobes - base);
        end
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        cycles(20);
        total++;
        if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 ||
            n_strobes != base || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL err_sticky: err=%b hold=%b done=%b strobes=%0d words=%0d required 1 1 0 0 0",
                     load_error, cpu_hold, load_done, n_strobes - base, words_loaded);
        end
    endtask

    task automatic test_framing();
        int base;
        do_reset();
        base = n_strobes;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h11);
        send_byte(8'h22, 1'b0);
        cycles(20);
        total++;
        if (load_error !== 1'b1 || words_loaded !== 16'd0 || n_strobes != base || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL framing: err=%b words=%0d strobes=%0d hold=%b required 1 0 0 1",
                     load_error, words_loaded, n_strobes - base, cpu_hold);
        end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = n_strobes;
        send(8'hA5);
        // A phantom byte here would be taken as the count high byte
        rx = 1'b0;
        cycles(1);
        rx = 1'b1;
        cycles(50);
        total++;
        if (load_error !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b1 || n_strobes != base) begin
            bad++;
            $display("FAIL glitch_idle: err=%b done=%b hold=%b strobes=%0d required 0 0 1 0",
                     load_error, load_done, cpu_hold, n_strobes - base);
        end
        send(8'h00); send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        cycles(20);
        total++;
        if (n_strobes - base != 1 || st_addr[base] !== 8'd0 || st_data[base] !== 32'hAABBCCDD ||
            load_done !== 1'b1) begin
            bad++;
            $display("FAIL glitch_then_load: strobes=%0d addr=%h data=%h done=%b required 1 00 aabbccdd 1",
                     n_strobes - base, st_addr[base], st_data[base], load_done);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        send(8'hA5); send(8'h00); send(8'h04);
        for (int w = 0; w < 2; w++) begin
            send(8'h01); send(8'h02); send(8'h03); send(8'(w));
        end
        cycles(20);
        total++;
        if (words_loaded !== 16'd2 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL partial: words=%0d done=%b hold=%b required 2 0 1", words_loaded, load_done, cpu_hold);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (words_loaded !== 16'd0 || load_done !== 1'b0 || cpu_hold !== 1'b1 || load_error !== 1'b0 ||
            imem_wr_en !== 1'b0 || imem_wr_addr !== 8'd0 || imem_wr_data !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: words=%0d done=%b hold=%b err=%b en=%b addr=%h data=%h required 0 0 1 0 0 00 00000000",
                     words_loaded, load_done, cpu_hold, load_error, imem_wr_en, imem_wr_addr, imem_wr_data);
        end
        cycles(3);
        reset = 1'b1;
        cycles(3);
        base = n_strobes;
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
        cycles(20);
        total++;
        if (n_strobes - base != 1 || st_addr[base] !== 8'd0 || st_data[base] !== 32'hCAFEF00D ||
            words_loaded !== 16'd1 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL reload: strobes=%0d addr=%h data=%h words=%0d done=%b hold=%b required 1 00 cafef00d 1 1 0",
                     n_strobes - base, st_addr[base], st_data[base], words_loaded, load_done, cpu_hold);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_oversize();
        test_framing();
        test_glitch();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
